// File: rtl/fp16_sa_pkg.sv
// Shared definitions for the FP16 systolic array slice.
// Operand width, zero constant and sequencer state encoding.
package fp16_sa_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage delay line used for per-lane diagonal skew.
// DEPTH of zero degenerates to a plain wire.
module sa_skew_line #(
    parameter int W     = 16,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n};
            assign q = d;
        end else begin : g_sr
            logic [W-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < DEPTH; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_fp16_seq.sv
// Operand sequencer for the NxN FP16 systolic array: feed, skew,
// drain and capture strobe around one K-deep job.
module systolic_fp16_seq
    import fp16_sa_pkg::*;
#(
    parameter int N     = 16,
    parameter int KW    = 8,
    parameter int DRAIN = 2 * N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    output logic [KW-1:0]     buf_rd_addr,
    input  logic [16*N-1:0]   buf_rd_a,
    input  logic [16*N-1:0]   buf_rd_b,
    output logic [16*N-1:0]   A_bus,
    output logic [16*N-1:0]   B_bus,
    output logic              arr_clr_n,
    output logic              cap_en
);

    logic [2:0]      state;
    logic [2:0]      nstate;
    logic [KW:0]     cnt;
    logic [KW-1:0]   klen_q;
    logic [KW-1:0]   last_addr;
    logic            v1;
    logic [16*N-1:0] cap_a;
    logic [16*N-1:0] cap_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:  if (start) nstate = S_CLR;
            S_CLR:   nstate = (klen_q == '0) ? S_DRAIN : S_FEED;
            S_FEED:
                if (cnt == {1'b0, klen_q} - 1'b1) nstate = S_DRAIN;
            S_DRAIN:
                if (cnt == (KW+1)'(DRAIN - 1)) nstate = S_CAP;
            S_CAP:   nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_CAP);
        cap_en      = (state == S_CAP);
        arr_clr_n   = (state != S_CLR);
        buf_rd_en   = (state == S_FEED);
        buf_rd_addr = buf_rd_en ? cnt[KW-1:0] : last_addr;
    end

    // cnt counts cycles spent in the current state; it is the k index in FEED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            klen_q    <= '0;
            last_addr <= '0;
            v1        <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
        end else begin
            cnt <= (nstate != state) ? '0 : cnt + 1'b1;
            if (state == S_IDLE && start) klen_q <= k_len;
            if (buf_rd_en) last_addr <= cnt[KW-1:0];
            v1    <= buf_rd_en;
            cap_a <= v1 ? buf_rd_a : {N{FP16_ZERO}};
            cap_b <= v1 ? buf_rd_b : {N{FP16_ZERO}};
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            sa_skew_line #(.W(FP16_W), .DEPTH(i)) u_skew_a (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (cap_a[16*i +: 16]),
                .q     (A_bus[16*i +: 16])
            );
            sa_skew_line #(.W(FP16_W), .DEPTH(i)) u_skew_b (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (cap_b[16*i +: 16]),
                .q     (B_bus[16*i +: 16])
            );
        end
    endgenerate

endmodule
